// File: rtl/salsa20_8_pkg.sv
// Shared types, constants and word-level helpers for the Salsa20/8 core.
package salsa20_8_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned NUM_WORDS     = 16;
    localparam int unsigned DOUBLE_ROUNDS = 4;
    localparam int unsigned ROT_A         = 7;
    localparam int unsigned ROT_B         = 9;
    localparam int unsigned ROT_C         = 13;
    localparam int unsigned ROT_D         = 18;

    typedef logic [WORD_W-1:0]                 word_t;
    typedef logic [NUM_WORDS-1:0][WORD_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic word_t rotl(input word_t v, input int unsigned n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

    // Sequential quarter-round applied in place to words (ia, ib, ic, id) of a block.
    function automatic block_t quarter_round(input block_t w,
                                             input logic [3:0] ia,
                                             input logic [3:0] ib,
                                             input logic [3:0] ic,
                                             input logic [3:0] id);
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        block_t r;
        r = w;
        a = w[ia];
        b = w[ib];
        c = w[ic];
        d = w[id];
        b = b ^ rotl(a + d, ROT_A);
        c = c ^ rotl(b + a, ROT_B);
        d = d ^ rotl(c + b, ROT_C);
        a = a ^ rotl(d + c, ROT_D);
        r[ia] = a;
        r[ib] = b;
        r[ic] = c;
        r[id] = d;
        return r;
    endfunction

    function automatic block_t block_add(input block_t a, input block_t b);
        block_t r;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            r[i[3:0]] = a[i[3:0]] + b[i[3:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/salsa20_8_if.sv
// Request/result bundle for the Salsa20/8 core: start strobe, input block, result block.
interface salsa20_8_if;
    import salsa20_8_pkg::*;

    logic  init;
    word_t x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7;
    word_t x8,  x9,  x10, x11, x12, x13, x14, x15;
    logic  valid;
    word_t out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7;
    word_t out8,  out9,  out10, out11, out12, out13, out14, out15;

    modport master (
        output init,
        output x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,
        output x8,  x9,  x10, x11, x12, x13, x14, x15,
        input  valid,
        input  out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7,
        input  out8,  out9,  out10, out11, out12, out13, out14, out15
    );

    modport slave (
        input  init,
        input  x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,
        input  x8,  x9,  x10, x11, x12, x13, x14, x15,
        output valid,
        output out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7,
        output out8,  out9,  out10, out11, out12, out13, out14, out15
    );

endinterface

// File: rtl/salsa20_8_doubleround.sv
// Combinational Salsa20 double-round: column round followed by row round.
module salsa_doubleround
    import salsa20_8_pkg::*;
(
    input  block_t din,
    output block_t dout
);

    block_t col;
    block_t row;

    // Quads within a round touch disjoint words, so chaining them is order-independent.
    always_comb begin
        col = din;
        col = quarter_round(col, 4'd0,  4'd4,  4'd8,  4'd12);
        col = quarter_round(col, 4'd5,  4'd9,  4'd13, 4'd1);
        col = quarter_round(col, 4'd10, 4'd14, 4'd2,  4'd6);
        col = quarter_round(col, 4'd15, 4'd3,  4'd7,  4'd11);
    end

    always_comb begin
        row = col;
        row = quarter_round(row, 4'd0,  4'd1,  4'd2,  4'd3);
        row = quarter_round(row, 4'd5,  4'd6,  4'd7,  4'd4);
        row = quarter_round(row, 4'd10, 4'd11, 4'd8,  4'd9);
        row = quarter_round(row, 4'd15, 4'd12, 4'd13, 4'd14);
    end

    assign dout = row;

endmodule

// File: rtl/salsa20_8.sv
// Salsa20/8 core: one double-round per clock, result = B + doubleround^4(B), registered.
module salsa20_8
    import salsa20_8_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    salsa20_8_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DOUBLE_ROUNDS + 1);

    state_t           state_q;
    state_t           state_d;
    block_t           work_q;
    block_t           work_d;
    block_t           save_q;
    block_t           save_d;
    block_t           out_q;
    block_t           out_d;
    logic             valid_q;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    block_t           x_blk;
    block_t           dr_out;
    logic             last_round_c;

    assign x_blk = {bus.x15, bus.x14, bus.x13, bus.x12, bus.x11, bus.x10, bus.x9, bus.x8,
                    bus.x7,  bus.x6,  bus.x5,  bus.x4,  bus.x3,  bus.x2,  bus.x1, bus.x0};

    salsa_doubleround u_dr (
        .din  (work_q),
        .dout (dr_out)
    );

    assign last_round_c = (cnt_q == CNT_W'(DOUBLE_ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.init)     state_d = ROUND;
            ROUND:   if (last_round_c) state_d = DONE;
            DONE:    if (!bus.init)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; init during ROUND is deliberately not looked at.
    always_comb begin
        work_d  = work_q;
        save_d  = save_q;
        out_d   = out_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.init) begin
                    work_d = x_blk;
                    save_d = x_blk;
                    cnt_d  = '0;
                end
            end
            ROUND: begin
                work_d = dr_out;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_round_c) begin
                    out_d   = block_add(dr_out, save_q);
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                if (!bus.init) valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work_q  <= '0;
            save_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            work_q  <= work_d;
            save_q  <= save_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid = valid_q;
    assign bus.out0  = out_q[0];
    assign bus.out1  = out_q[1];
    assign bus.out2  = out_q[2];
    assign bus.out3  = out_q[3];
    assign bus.out4  = out_q[4];
    assign bus.out5  = out_q[5];
    assign bus.out6  = out_q[6];
    assign bus.out7  = out_q[7];
    assign bus.out8  = out_q[8];
    assign bus.out9  = out_q[9];
    assign bus.out10 = out_q[10];
    assign bus.out11 = out_q[11];
    assign bus.out12 = out_q[12];
    assign bus.out13 = out_q[13];
    assign bus.out14 = out_q[14];
    assign bus.out15 = out_q[15];

endmodule

// File: tb/tb_salsa20_8.sv
// Self-checking bench for salsa20_8: vector table, reference model scoreboard, corner sequences.
module tb_salsa20_8;

    typedef logic [15:0][31:0] blk_t;
    typedef struct {
        blk_t blk;
        blk_t exp;
        bit   hold;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    blk_t sb_q[$];

    salsa20_8_if bus();

    salsa20_8 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] r32(input logic [31:0] v, input int n);
        logic [63:0] t;
        t = {v, v} << n;
        return t[63:32];
    endfunction

    // Reference Salsa20/8 in the classic in-place 8-round form.
    function automatic blk_t model(input blk_t b);
        logic [31:0] x [16];
        blk_t o;
        for (int i = 0; i < 16; i++) x[i] = b[i];
        for (int r = 0; r < 8; r += 2) begin
            x[4]  ^= r32(x[0]  + x[12], 7);  x[8]  ^= r32(x[4]  + x[0],  9);
            x[12] ^= r32(x[8]  + x[4], 13);  x[0]  ^= r32(x[12] + x[8], 18);
            x[9]  ^= r32(x[5]  + x[1],  7);  x[13] ^= r32(x[9]  + x[5],  9);
            x[1]  ^= r32(x[13] + x[9], 13);  x[5]  ^= r32(x[1]  + x[13], 18);
            x[14] ^= r32(x[10] + x[6],  7);  x[2]  ^= r32(x[14] + x[10], 9);
            x[6]  ^= r32(x[2]  + x[14], 13); x[10] ^= r32(x[6]  + x[2], 18);
            x[3]  ^= r32(x[15] + x[11], 7);  x[7]  ^= r32(x[3]  + x[15], 9);
            x[11] ^= r32(x[7]  + x[3], 13);  x[15] ^= r32(x[11] + x[7], 18);
            x[1]  ^= r32(x[0]  + x[3],  7);  x[2]  ^= r32(x[1]  + x[0],  9);
            x[3]  ^= r32(x[2]  + x[1], 13);  x[0]  ^= r32(x[3]  + x[2], 18);
            x[6]  ^= r32(x[5]  + x[4],  7);  x[7]  ^= r32(x[6]  + x[5],  9);
            x[4]  ^= r32(x[7]  + x[6], 13);  x[5]  ^= r32(x[4]  + x[7], 18);
            x[11] ^= r32(x[10] + x[9],  7);  x[8]  ^= r32(x[11] + x[10], 9);
            x[9]  ^= r32(x[8]  + x[11], 13); x[10] ^= r32(x[9]  + x[8], 18);
            x[12] ^= r32(x[15] + x[14], 7);  x[13] ^= r32(x[12] + x[15], 9);
            x[14] ^= r32(x[13] + x[12], 13); x[15] ^= r32(x[14] + x[13], 18);
        end
        for (int i = 0; i < 16; i++) o[i] = x[i] + b[i];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input blk_t b);
        bus.x0  = b[0];  bus.x1  = b[1];  bus.x2  = b[2];  bus.x3  = b[3];
        bus.x4  = b[4];  bus.x5  = b[5];  bus.x6  = b[6];  bus.x7  = b[7];
        bus.x8  = b[8];  bus.x9  = b[9];  bus.x10 = b[10]; bus.x11 = b[11];
        bus.x12 = b[12]; bus.x13 = b[13]; bus.x14 = b[14]; bus.x15 = b[15];
    endtask

    function automatic blk_t get_out();
        return {bus.out15, bus.out14, bus.out13, bus.out12, bus.out11, bus.out10, bus.out9, bus.out8,
                bus.out7,  bus.out6,  bus.out5,  bus.out4,  bus.out3,  bus.out2,  bus.out1, bus.out0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input blk_t act, input blk_t exp);
        for (int i = 0; i < 16; i++) chk($sformatf("%s out%0d", name, i), act[i], exp[i]);
    endtask

    // Sample init at the next edge (e0) with block b on x*.
    task automatic start(input blk_t b);
        set_x(b);
        bus.init = 1'b1;
        tick();
    endtask

    // Wait for valid, check latency from the last edge, pop the scoreboard and compare.
    task automatic wait_result(input string name, input int exp_lat);
        int   lat;
        blk_t exp;
        lat = 0;
        while (!bus.valid && lat < 12) begin
            tick();
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", name);
        end else begin
            exp = sb_q.pop_front();
            chk_blk(name, get_out(), exp);
        end
    endtask

    vec_t vecs[5];
    blk_t rfc_in, rfc_out, zero_blk, rep, a_blk, b_blk, snap;
    logic [31:0] rep_w [4];

    initial begin
        zero_blk = '0;
        rfc_in  = {32'h5ec2b8b8, 32'h8dc6ebed, 32'h2948c709, 32'h291d0276,
                   32'h32aac55a, 32'h4b1e1214, 32'h853d9bdf, 32'h19f324ee,
                   32'h1d3bcd6d, 32'h1146f80d, 32'hb5c1618c, 32'h5b55eeba,
                   32'h268f7141, 32'he640a97c, 32'h86c93e4f, 32'h219a877e};
        rfc_out = {32'h818f61c7, 32'h3d67ad24, 32'h5c74912c, 32'h10cc24e4,
                   32'hba966da0, 32'hb7c56bfe, 32'hbce6c9e3, 32'h683139b4,
                   32'h292f6896, 32'h631c7bfd, 32'h7d33fda2, 32'h81214b04,
                   32'h05ef0c02, 32'hcbca813b, 32'h99cc0866, 32'h9c851fa4};
        rep_w[0] = 32'hae042d63; rep_w[1] = 32'hc3823f85;
        rep_w[2] = 32'h2d0a38cd; rep_w[3] = 32'h7af25f75;
        for (int i = 0; i < 16; i++) rep[i] = rep_w[i % 4];

        vecs[0] = '{blk: zero_blk, exp: zero_blk,     hold: 1'b0};
        vecs[1] = '{blk: rfc_in,   exp: rfc_out,      hold: 1'b0};
        vecs[2] = '{blk: rep,      exp: model(rep),   hold: 1'b1};
        for (int v = 3; v < 5; v++) begin
            for (int i = 0; i < 16; i++) a_blk[i] = $urandom;
            vecs[v] = '{blk: a_blk, exp: model(a_blk), hold: 1'b0};
        end

        reset    = 1'b1;
        bus.init = 1'b0;
        set_x(zero_blk);
        tick();
        tick();
        chk("reset valid", 32'(bus.valid), 32'd0);
        chk_blk("reset", get_out(), zero_blk);
        reset = 1'b0;

        // Back-to-back table vectors; each ends in IDLE so the next init is taken at once.
        for (int v = 0; v < 5; v++) begin
            start(vecs[v].blk);
            sb_q.push_back(vecs[v].exp);
            if (!vecs[v].hold) bus.init = 1'b0;
            wait_result($sformatf("vec%0d", v), 4);
            if (vecs[v].hold) begin
                repeat (3) begin
                    tick();
                    chk($sformatf("vec%0d hold valid", v), 32'(bus.valid), 32'd1);
                    chk($sformatf("vec%0d hold out0", v), bus.out0, vecs[v].exp[0]);
                end
                bus.init = 1'b0;
            end
            tick();
            chk($sformatf("vec%0d valid fall", v), 32'(bus.valid), 32'd0);
            chk_blk($sformatf("vec%0d after fall", v), get_out(), vecs[v].exp);
        end

        // Reset at e0+2 aborts the computation without producing a result.
        start(rfc_in);
        bus.init = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("abort valid c%0d", k), 32'(bus.valid), 32'd0);
            chk_blk($sformatf("abort c%0d", k), get_out(), zero_blk);
            tick();
        end
        for (int i = 0; i < 16; i++) a_blk[i] = $urandom;
        start(a_blk);
        sb_q.push_back(model(a_blk));
        bus.init = 1'b0;
        wait_result("post-abort", 4);
        tick();

        // init is honoured at the first edge after reset is released.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start(rfc_in);
        sb_q.push_back(rfc_out);
        bus.init = 1'b0;
        wait_result("post-reset", 4);
        tick();

        // x* changes and an init pulse during ROUND must not disturb the latched block.
        for (int i = 0; i < 16; i++) a_blk[i] = $urandom;
        for (int i = 0; i < 16; i++) b_blk[i] = $urandom;
        start(a_blk);
        sb_q.push_back(model(a_blk));
        bus.init = 1'b0;
        tick();
        set_x(b_blk);
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        wait_result("round-ignore", 2);
        snap = get_out();
        set_x(rfc_in);
        tick();
        chk("round-ignore valid fall", 32'(bus.valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("no restart valid c%0d", k), 32'(bus.valid), 32'd0);
        end
        chk_blk("round-ignore held", get_out(), model(a_blk));
        chk("round-ignore snap out7", snap[7], model(a_blk)[7]);

        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
